// File: rtl/zoom_read_sched.sv
`timescale 1ns/1ps
// zoom_read_sched: 2x-zoom read-request scheduler for the 720p frame buffer.
// Walks a 640x360 window of the 1280x720 frame, issuing every source row twice.
// Ports:
//   clk_in, rst_n_in           : UI clock, async active-low reset
//   calib_done_in              : memory calibration complete, starts scheduling
//   zoom_view_x, zoom_view_y   : window origin, sampled only between frames
//   read_axis_af               : read FIFO almost full, throttles requests
//   req_valid/req_ready/req_addr : read request stream (128-bit word address)
//   rsp_valid                  : read response accepted
//   rsp_tlast, frame_done      : last response word of a frame, and pulse after
//   outstanding                : requests issued but not yet answered
module zoom_read_sched #(
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        calib_done_in,
    input  logic [11:0] zoom_view_x,
    input  logic [10:0] zoom_view_y,
    input  logic        read_axis_af,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [26:0] req_addr,
    input  logic        rsp_valid,
    output logic        rsp_tlast,
    output logic        frame_done,
    output logic [3:0]  outstanding
);
    localparam logic [3:0]  MAX_O    = 4'(MAX_OUTSTANDING);
    localparam logic [26:0] ROW_W    = 27'd160;
    localparam logic [15:0] RSP_LAST = 16'd57599;

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE} state_t;

    state_t      state;
    logic [6:0]  col;
    logic        dup;
    logic [8:0]  srow;
    logic [26:0] row_base;
    logic [6:0]  x0w;
    logic [15:0] rsp_cnt;
    logic [3:0]  out_cnt;

    logic [11:0] vx;
    logic [6:0]  x0w_nxt;
    logic [10:0] y0;
    logic [26:0] y0_w;
    logic [26:0] row_base_nxt;
    logic        req_hs;
    logic        last_req;

    // View clamping keeps the window inside the stored frame.
    assign vx           = zoom_view_x >> 3;
    assign x0w_nxt      = (vx > 12'd80) ? 7'd80 : vx[6:0];
    assign y0           = (zoom_view_y > 11'd360) ? 11'd360 : zoom_view_y;
    assign y0_w         = {16'd0, y0};
    assign row_base_nxt = (y0_w << 7) + (y0_w << 5);

    assign req_valid = (state == ISSUE) && (out_cnt < MAX_O) && !read_axis_af;
    assign req_addr  = (state == ISSUE)
                     ? row_base + {20'd0, x0w} + {20'd0, col}
                     : 27'd0;
    assign req_hs    = req_valid && req_ready;
    assign last_req  = req_hs && (srow == 9'd359) && dup && (col == 7'd79);

    assign rsp_tlast   = (rsp_cnt == RSP_LAST);
    assign outstanding = out_cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            col      <= '0;
            dup      <= 1'b0;
            srow     <= '0;
            row_base <= '0;
            x0w      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (calib_done_in)
                        state <= LOAD;
                end
                LOAD: begin
                    x0w      <= x0w_nxt;
                    row_base <= row_base_nxt;
                    col      <= '0;
                    dup      <= 1'b0;
                    srow     <= '0;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    if (req_hs) begin
                        if (col == 7'd79) begin
                            col <= '0;
                            dup <= ~dup;
                            // Second pass of a row done: step to next source row.
                            if (dup) begin
                                srow     <= srow + 9'd1;
                                row_base <= row_base + ROW_W;
                            end
                        end else begin
                            col <= col + 7'd1;
                        end
                        // Next frame starts without waiting for responses.
                        if (last_req)
                            state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating in-flight counter; a stray response at zero is ignored.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_cnt <= '0;
        end else begin
            unique case (1'b1)
                req_hs && !rsp_valid && (out_cnt < MAX_O):
                    out_cnt <= out_cnt + 4'd1;
                rsp_valid && !req_hs && (out_cnt != 4'd0):
                    out_cnt <= out_cnt - 4'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rsp_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= rsp_valid && rsp_tlast;
            if (rsp_valid)
                rsp_cnt <= rsp_tlast ? 16'd0 : rsp_cnt + 16'd1;
        end
    end
endmodule

// File: doc/zoom_read_sched.md
# zoom_read_sched

Read-request scheduler for the 2x zoom display mode of the DDR3 720p frame buffer. It sits beside the traffic generator's read path and drives the read-request stream while zoom is enabled. It walks a 640x360-pixel window of the stored 1280x720 frame and requests each source row twice, for vertical line doubling. It throttles on outstanding requests and read-FIFO almost-full, and generates TLAST for the returning read data.

## Interface
- `MAX_OUTSTANDING`, default 8: maximum requests issued but not yet answered.
- `clk_in` input, 1 bit: DDR3 UI clock; the only clock.
- `rst_n_in` input, 1 bit: reset, asynchronous, active-low.
- `calib_done_in` input, 1 bit: MIG `init_calib_complete`.
- `zoom_view_x` input, 12 bits: window left edge, in pixels.
- `zoom_view_y` input, 11 bits: window top edge, in rows.
- `read_axis_af` input, 1 bit: read FIFO almost full.
- `req_valid` output, 1 bit: read request valid.
- `req_ready` input, 1 bit: MIG accepts the request (`app_rdy` while in the read state).
- `req_addr` output, 27 bits: 128-bit word address. The parent shifts it left by 3 to form `app_addr`.
- `rsp_valid` input, 1 bit: read-response handshake (`read_axis_valid && read_axis_ready`).
- `rsp_tlast` output, 1 bit: TLAST for the current response word.
- `frame_done` output, 1 bit: one-cycle pulse when the response carrying TLAST is accepted.
- `outstanding` output, 4 bits: current outstanding count.

## Operation
- Frame geometry:
  - 160 words per row; 115200 words per frame.
  - One zoomed frame = 360 source rows x 2 repeats x 80 words = 57600 requests and 57600 responses.
- View capture happens in LOAD only:
  - `x0w = min(zoom_view_x >> 3, 80)`.
  - `y0 = min(zoom_view_y, 360)`.
  - `row_base = y0*160`, computed as `(y0<<7) + (y0<<5)`; no multiplier.
  - View inputs are ignored at all other times, so there is no mid-frame tearing.
- States:
  - IDLE: `req_valid=0`. Moves to LOAD when `calib_done_in=1`.
  - LOAD: one cycle. Captures the view and clears `col`, `dup` and `srow`. Moves to ISSUE.
  - ISSUE:
    - `req_valid = (outstanding < MAX_OUTSTANDING) && !read_axis_af`.
    - `req_addr = row_base + x0w + col`.
- Counter advance on a request handshake (`req_valid && req_ready`):
  - `col` counts 0..79.
  - When `col` wraps, `dup` toggles.
  - When `dup` wraps 1->0, `srow` increments and `row_base += 160`.
  - After the request with `srow=359, dup=1, col=79`: go to LOAD, and the next frame begins.
  - Request issue does not wait for the responses to drain.
- Outstanding counter:
  - +1 on a request handshake, -1 on `rsp_valid`; both in the same cycle leaves it unchanged.
  - Saturates: never exceeds `MAX_OUTSTANDING` and never underflows. `rsp_valid` at 0 is a protocol error; the counter holds at 0.
- Response counter:
  - `rsp_cnt` counts 0..57599, increments on `rsp_valid`, and wraps to 0.
  - It is independent of the request side.
- `rsp_tlast = (rsp_cnt == 57599)`, combinational from the register.
- `frame_done = rsp_valid && rsp_tlast`, registered, so it pulses the cycle after.
- Arithmetic: all address math is 27 bits wide. Maximum address = 719*160 + 159 = 115199.
- `calib_done_in` falling while in ISSUE has no effect; only reset returns the block to IDLE.

## Timing
- Reset (async assert, deassertion synchronous to `clk_in`) gives:
  - state IDLE, all counters 0, `row_base=0`, `x0w=0`;
  - `req_valid=0`, `req_addr=0`, `rsp_tlast=0`, `frame_done=0`, `outstanding=0`.
- Reset mid-frame drops all counts immediately. In-flight MIG responses must be flushed by the parent.
- `req_addr` is forced to 0 outside ISSUE.
- First request: cycle N sees `calib_done_in` high in IDLE; LOAD at N+1; `req_valid` may be high from N+2.
- Sustained rate with `req_ready=1`, no throttling and prompt responses: 1 request per cycle.
- LOAD inserts exactly one bubble between frames.
- `req_valid` and `req_addr` stay stable while `req_valid && !req_ready`, unless `read_axis_af` rises. `req_valid` may drop on af; this is allowed because the request is not an AXI stream.
- Throttle response:
  - `req_valid` falls combinationally in the cycle `outstanding` reaches the limit or af rises.
  - It rises again the cycle after a response is accepted.

## Test plan
- View (0,0), `req_ready=1`, responses returned 2 cycles after each request:
  - address order 0..79, then 0..79 again, then 160..239.
  - 57600th request has address 57519 (359*160+79).
- View (640,360): first address 57680; last address 115199; no address exceeds 115199.
- View (1000,500) clamps to x0w=80, y0=360, giving first address 57680.
- `req_ready=1`, no responses: exactly 8 requests issued, then `req_valid=0` with `outstanding=8`. One response re-enables exactly one request.
- 57600 responses: `rsp_tlast` high only on the 57600th; `frame_done` pulses once, one cycle later; `rsp_cnt` wraps to 0.
- Change `zoom_view_x` mid-frame: no effect until the cycle after the 57600th request.
- Assert `rst_n_in` mid-burst: all outputs are 0 immediately (asynchronously).
- Request and response handshake in the same cycle: `outstanding` unchanged.
